data_memory_line: RTL

//  Line-granular (256-bit) backing data memory directly downstream of the data cache.

---
 rtl/data_memory_line.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/data_memory_line.sv
// Line-granular backing memory behind the data cache: one read or write per
// enable/ack handshake, acknowledged after a fixed latency to mimic DRAM timing.
`timescale 1ns/1ps

module data_memory_line #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  rd_cnt_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                accept_s;
  logic                commit_s;
  logic [LAT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    idx_r;
  logic [LINE_W-1:0]   wdata_r;
  logic                write_r;
  logic                ack_r;
  logic                busy_r;
  logic [LINE_W-1:0]   data_r;
  logic [CNT_W-1:0]    rd_cnt_r;
  logic [CNT_W-1:0]    wr_cnt_r;
  logic [LINE_W-1:0]   mem_r [DEPTH];

  // Offset bits and bits above the index field are deliberately ignored (aliasing).
  logic unused_addr_s;
  assign unused_addr_s = ^{addr_i[4:0], addr_i[31:5+IDX_W]};

  // Next-state decode; the commit edge is the one where the count reaches LATENCY.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable_i) begin
          accept_s = 1'b1;
          state_s  = ST_BUSY;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == LAT_W'(LATENCY)) begin
          commit_s = 1'b1;
          state_s  = ST_ACK;
        end else begin
          state_s  = ST_BUSY;
        end
      end
      ST_ACK:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Control state, latency counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {LAT_W{1'b0}};
      ack_r    <= 1'b0;
      busy_r   <= 1'b0;
      data_r   <= {LINE_W{1'b0}};
      rd_cnt_r <= {CNT_W{1'b0}};
      wr_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      ack_r   <= commit_s;
      busy_r  <= (state_s != ST_IDLE);
      if (accept_s) begin
        cnt_r <= LAT_W'(1);
      end else if (state_r == ST_BUSY) begin
        cnt_r <= cnt_r + LAT_W'(1);
      end else begin
        cnt_r <= {LAT_W{1'b0}};
      end
      if (commit_s && write_r) begin
        if (wr_cnt_r != {CNT_W{1'b1}}) begin
          wr_cnt_r <= wr_cnt_r + CNT_W'(1);
        end else begin
          wr_cnt_r <= wr_cnt_r;
        end
      end else if (commit_s) begin
        data_r <= mem_r[idx_r];
        if (rd_cnt_r != {CNT_W{1'b1}}) begin
          rd_cnt_r <= rd_cnt_r + CNT_W'(1);
        end else begin
          rd_cnt_r <= rd_cnt_r;
        end
      end else begin
        data_r <= data_r;
      end
    end
  end

  // Request capture and array write; neither holds state that needs a reset.
  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      idx_r   <= addr_i[5 +: IDX_W];
      wdata_r <= data_i;
      write_r <= write_i;
    end else begin
      idx_r   <= idx_r;
      wdata_r <= wdata_r;
      write_r <= write_r;
    end
    if (commit_s && write_r) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  assign ack_o    = ack_r;
  assign busy_o   = busy_r;
  assign data_o   = data_r;
  assign rd_cnt_o = rd_cnt_r;
  assign wr_cnt_o = wr_cnt_r;

endmodule
